// File: rtl/stack_pkg.sv
// Shared stack-engine definitions: FSM state encoding and default burst geometry.
// The default MAX_WORDS matches the register-file spill/restore burst size.
package stack_pkg;

  localparam int unsigned STACK_WORD_W    = 16;
  localparam int unsigned STACK_MAX_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_ram_sp.sv
// Single-port synchronous word RAM with registered read data; contents are not reset.
// Ports: clock, we (write enable), addr (word address), din (write word), dout (read word, 1-cycle latency).
module stack_ram_sp #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write-first is irrelevant here: the engine never reads and writes in the same cycle.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/stack_burst_ram.sv
// Burst engine that owns a single-port word RAM and moves 0..MAX_WORDS words per request
// between a packed bus and consecutive RAM addresses, using a level-held start/done handshake.
// Ports: clock, reset_n (async, active-low), start/write/address/words/wdata (request, sampled in IDLE),
//        rdata (packed read data, word 0 in MSBs), busy (in RUN), done (burst complete), error (rejected).
module stack_burst_ram
  import stack_pkg::*;
#(
  parameter int unsigned WORD_W    = STACK_WORD_W,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned MAX_WORDS = STACK_MAX_WORDS
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        write,
  input  logic [ADDR_W-1:0]           address,
  input  logic [ADDR_W-1:0]           words,
  input  logic [MAX_WORDS*WORD_W-1:0] wdata,
  output logic [MAX_WORDS*WORD_W-1:0] rdata,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int unsigned BUS_W  = MAX_WORDS * WORD_W;
  localparam int unsigned RAM_AW = $clog2(DEPTH);
  localparam int unsigned IDX_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned SUM_W  = ADDR_W + 1;

  state_e              state_q, state_d;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   words_q;
  logic [BUS_W-1:0]    wdata_q;
  logic [IDX_W-1:0]    idx_q;

  logic                ram_we_c;
  logic [RAM_AW-1:0]   ram_addr_c;
  logic [WORD_W-1:0]   ram_din_c;
  logic [WORD_W-1:0]   ram_dout;
  logic                capture_c;
  logic                range_err_c;
  logic [SUM_W-1:0]    end_sum_c;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus RAM/capture strobes; start low in RUN aborts before any further write.
  always_comb begin
    state_d     = state_q;
    ram_we_c    = 1'b0;
    ram_din_c   = '0;
    capture_c   = 1'b0;
    end_sum_c   = {1'b0, address} + {1'b0, words};
    range_err_c = (words > ADDR_W'(MAX_WORDS)) || (end_sum_c > SUM_W'(DEPTH));
    ram_addr_c  = RAM_AW'(addr_q + ADDR_W'(idx_q));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (range_err_c)        state_d = ST_ERR;
          else if (words == '0)   state_d = ST_DONE;
          else                    state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (write_q) begin
          ram_we_c  = 1'b1;
          ram_din_c = wdata_q[(MAX_WORDS - 32'd1 - 32'(idx_q)) * WORD_W +: WORD_W];
          if (ADDR_W'(idx_q) + ADDR_W'(1) == words_q) state_d = ST_DONE;
        end else begin
          // RAM output in cycle idx belongs to word idx-1; one extra cycle drains the last word.
          capture_c = (idx_q != '0);
          if (ADDR_W'(idx_q) == words_q) state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, word index, registered status flags and read-data packing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      words_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      busy  <= (state_d == ST_RUN);
      done  <= (state_d == ST_DONE);
      error <= (state_d == ST_ERR);
      if (state_q == ST_IDLE && start) begin
        write_q <= write;
        addr_q  <= address;
        words_q <= words;
        wdata_q <= wdata;
        idx_q   <= '0;
        if (state_d == ST_RUN && !write) rdata <= '0;
      end else if (state_q == ST_RUN && start) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (capture_c) begin
        rdata[(MAX_WORDS - 32'(idx_q)) * WORD_W +: WORD_W] <= ram_dout;
      end
    end
  end

  stack_ram_sp #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .din   (ram_din_c),
    .dout  (ram_dout)
  );

endmodule

// File: tb/tb_stack_burst_ram.sv
// Bench for stack_burst_ram: directed handshake/boundary steps plus random bursts against an
// array model of RAM contents and expected latency/rdata derived from the burst rules.
module tb_stack_burst_ram;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned BUS_W     = WORD_W * MAX_WORDS;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               start;
  logic               write;
  logic [ADDR_W-1:0]  address;
  logic [ADDR_W-1:0]  words;
  logic [BUS_W-1:0]   wdata;
  logic [BUS_W-1:0]   rdata;
  logic               busy;
  logic               done;
  logic               error;

  logic [WORD_W-1:0]  model_mem [DEPTH];
  logic [BUS_W-1:0]   exp_rdata;
  int                 n_checks = 0;
  int                 n_pass   = 0;

  stack_burst_ram #(
    .WORD_W    (WORD_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .write   (write),
    .address (address),
    .words   (words),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] v;
    for (int k = 0; k < BUS_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full request: raise start, count edges to done/error, check flags, data and busy time,
  // optionally hold start for `hold` extra cycles, then drop start and check the flag falls.
  task automatic run_burst(input bit wr, input int unsigned addr, input int unsigned nw,
                           input logic [BUS_W-1:0] wd, input int hold, input string tag);
    int edges = 0;
    int bcnt  = 0;
    bit exp_err;
    int exp_lat;
    exp_err = (nw > MAX_WORDS) || (addr + nw > DEPTH);
    exp_lat = (exp_err || nw == 0) ? 1 : (wr ? nw + 1 : nw + 2);
    @(negedge clock);
    write   = wr;
    address = ADDR_W'(addr);
    words   = ADDR_W'(nw);
    wdata   = wd;
    start   = 1'b1;
    do begin
      @(posedge clock); #1;
      edges++;
      if (busy) bcnt++;
    end while (!done && !error && edges < 64);
    if (!exp_err && nw > 0) begin
      if (wr) begin
        for (int i = 0; i < int'(nw); i++) model_mem[addr + i] = wd[(MAX_WORDS-1-i)*WORD_W +: WORD_W];
      end else begin
        exp_rdata = '0;
        for (int i = 0; i < int'(nw); i++) exp_rdata[(MAX_WORDS-1-i)*WORD_W +: WORD_W] = model_mem[addr + i];
      end
    end
    chk({tag, "_latency"}, BUS_W'(edges), BUS_W'(exp_lat));
    chk({tag, "_error"}, BUS_W'(error), BUS_W'(exp_err));
    chk({tag, "_done"}, BUS_W'(done), BUS_W'(!exp_err));
    chk({tag, "_busy_cycles"}, BUS_W'(bcnt), BUS_W'((exp_err || nw == 0) ? 0 : (wr ? nw : nw + 1)));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk({tag, "_flag_held"}, BUS_W'(done | error), BUS_W'(1));
    end
    @(negedge clock);
    start = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_flag_drop"}, BUS_W'({busy, done, error}), BUS_W'(0));
  endtask

  initial begin
    logic [BUS_W-1:0] wd;
    reset_n = 1'b0;
    start   = 1'b0;
    write   = 1'b0;
    address = '0;
    words   = '0;
    wdata   = '0;
    exp_rdata = '0;
    #3;
    chk("reset_flags", BUS_W'({busy, done, error}), BUS_W'(0));
    chk("reset_rdata", rdata, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Fill the whole RAM so every later read has a known model value.
    for (int b = 0; b < int'(DEPTH / MAX_WORDS); b++) run_burst(1'b1, b * MAX_WORDS, MAX_WORDS, rand_bus(), 0, "fill");

    // Single-word round trip.
    wd = '0;
    wd[BUS_W-1 -: WORD_W] = 16'hBEEF;
    run_burst(1'b1, 5, 1, wd, 0, "single_wr");
    run_burst(1'b0, 5, 1, '0, 0, "single_rd");
    wd = '0;
    wd[BUS_W-1 -: WORD_W] = 16'hBEEF;
    chk("single_rd_beef", rdata, wd);

    // Full 16-word spill and restore.
    for (int i = 0; i < int'(MAX_WORDS); i++) wd[(MAX_WORDS-1-i)*WORD_W +: WORD_W] = WORD_W'(16'h1000 + i);
    run_burst(1'b1, 100, 16, wd, 0, "spill");
    run_burst(1'b0, 100, 16, '0, 0, "restore");
    chk("restore_exact", rdata, wd);

    // Range rejection and zero-length read keeping previous rdata.
    run_burst(1'b1, 1020, 8, rand_bus(), 0, "bound_1020");
    run_burst(1'b0, 1020, 4, '0, 0, "bound_readback");
    run_burst(1'b1, 0, 17, rand_bus(), 0, "too_long");
    run_burst(1'b1, 16'hFFF0, 16, rand_bus(), 0, "addr_wrap");
    run_burst(1'b0, 1008, 16, '0, 0, "last_block");
    run_burst(1'b0, 300, 0, '0, 0, "zero_len");

    // Hold start after done, then restart on the very next cycle.
    run_burst(1'b1, 40, 3, rand_bus(), 5, "hold");
    run_burst(1'b0, 40, 3, '0, 0, "hold_next");

    // Abort an 8-word write at index 3: only words 0..2 land in RAM.
    wd = rand_bus();
    @(negedge clock);
    write = 1'b1; address = 16'd200; words = 16'd8; wdata = wd; start = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock); #1;
    chk("abort_idle", BUS_W'({busy, done, error}), BUS_W'(0));
    for (int i = 0; i < 3; i++) model_mem[200 + i] = wd[(MAX_WORDS-1-i)*WORD_W +: WORD_W];
    repeat (3) @(posedge clock); #1;
    chk("abort_no_done", BUS_W'(done), BUS_W'(0));
    run_burst(1'b0, 200, 8, '0, 0, "abort_readback");

    // Asynchronous reset in the middle of a read.
    @(negedge clock);
    write = 1'b0; address = 16'd100; words = 16'd16; start = 1'b1;
    repeat (6) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", BUS_W'(busy), BUS_W'(0));
    chk("rst_mid_rdata", rdata, '0);
    exp_rdata = '0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_burst(1'b0, 100, 16, '0, 0, "post_reset_rd");

    // Random bursts.
    for (int r = 0; r < 60; r++) begin
      int unsigned a, n;
      n = $urandom_range(0, 17);
      a = ($urandom_range(0, 3) == 0) ? DEPTH - $urandom_range(0, 20) : $urandom_range(0, DEPTH - 1);
      run_burst(bit'($urandom_range(0, 1)), a, n, rand_bus(), $urandom_range(0, 2), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
